// File: rtl/gtlp_bus_receiver.sv
// GTL+ bus receiver: pad synchronizer, glitch filter, edge strobes and contention flag; O lags a held pad step by
// SYNC_STAGES+FILTER_CYCLES edges, no backpressure. Define GLBL_GTS_EN to mask contention checking while glbl.GTS is high.
module gtlp_bus_receiver #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic INIT          = 1'b1
) (
    input  logic C,
    input  logic CLR,
    input  logic I,
    input  logic CE,
    input  logic T_LOCAL,
    input  logic I_LOCAL,
    input  logic ERR_CLR,
    output logic O,
    output logic RISE,
    output logic FALL,
    output logic ERR
);

    localparam logic [3:0] CNT_MAX = 4'(FILTER_CYCLES - 1);
    localparam logic [2:0] DS_MAX  = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             ds_q, ds_d;
    logic                   o_q, o_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   err_q, err_d;
    logic                   il_prev_q;
    logic                   s;
    logic                   gts;
    logic                   driving;
    logic                   err_set;

`ifdef GLBL_GTS_EN
    assign gts = glbl.GTS;
`else
    assign gts = 1'b0;
`endif

    assign s       = sync_q[SYNC_STAGES-1];
    assign driving = ~T_LOCAL & ~gts;
    assign err_set = (ds_q == DS_MAX) && (s != I_LOCAL) && !gts;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], I};
        cnt_d  = cnt_q;
        o_d    = o_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (CE) begin
            if (s == o_q) begin
                cnt_d = 4'd0;
            end else if (cnt_q == CNT_MAX) begin
                // Strobes are registered alongside O so they line up with the new level.
                o_d    = s;
                cnt_d  = 4'd0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end

        if (driving && (I_LOCAL == il_prev_q)) begin
            ds_d = (ds_q == DS_MAX) ? ds_q : ds_q + 3'd1;
        end else begin
            ds_d = 3'd0;
        end

        // A fresh contention event outranks a simultaneous clear.
        err_d = err_set | (err_q & ~ERR_CLR);
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            sync_q    <= {SYNC_STAGES{INIT}};
            cnt_q     <= 4'd0;
            ds_q      <= 3'd0;
            o_q       <= INIT;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            err_q     <= 1'b0;
            il_prev_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            ds_q      <= ds_d;
            o_q       <= o_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            err_q     <= err_d;
            il_prev_q <= I_LOCAL;
        end
    end

    assign O    = o_q;
    assign RISE = rise_q;
    assign FALL = fall_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_gtlp_bus_receiver.sv
// Bench for gtlp_bus_receiver at default parameters: directed scenarios plus randomized traffic against a
// behavioural model (pad delay line, consecutive-mismatch streak, stable-drive run length).
module tb_gtlp_bus_receiver;

    localparam int SS = 2;
    localparam int FC = 4;

    logic C = 1'b0;
    logic CLR, I, CE, T_LOCAL, I_LOCAL, ERR_CLR;
    logic O, RISE, FALL, ERR;

    int tests_run    = 0;
    int tests_failed = 0;

    bit m_hist[$];
    bit m_o, m_rise, m_fall, m_err, m_prev_il;
    int m_streak, m_ds;

    gtlp_bus_receiver #(.SYNC_STAGES(SS), .FILTER_CYCLES(FC), .INIT(1'b1)) dut (
        .C(C), .CLR(CLR), .I(I), .CE(CE), .T_LOCAL(T_LOCAL), .I_LOCAL(I_LOCAL),
        .ERR_CLR(ERR_CLR), .O(O), .RISE(RISE), .FALL(FALL), .ERR(ERR)
    );

    always #5 C = ~C;

    task automatic model_reset();
        m_hist.delete();
        for (int k = 0; k < SS; k++) m_hist.push_back(1'b1);
        m_o = 1'b1; m_rise = 1'b0; m_fall = 1'b0; m_err = 1'b0;
        m_prev_il = 1'b0; m_streak = 0; m_ds = 0;
    endtask

    // Advance one rising edge; the model sees the inputs that were set up before the edge.
    task automatic tick();
        bit i_s, ce_s, t_s, il_s, ec_s, s_seen, stable, set;
        i_s = I; ce_s = CE; t_s = T_LOCAL; il_s = I_LOCAL; ec_s = ERR_CLR;
        @(posedge C);
        #1;
        if (CLR) begin
            model_reset();
        end else begin
            s_seen = m_hist[0];
            m_hist.push_back(i_s);
            void'(m_hist.pop_front());
            m_rise = 1'b0; m_fall = 1'b0;
            if (ce_s) begin
                if (s_seen != m_o) begin
                    m_streak++;
                    if (m_streak == FC) begin
                        m_o = s_seen; m_rise = s_seen; m_fall = !s_seen; m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
            set    = (m_ds == SS + 1) && (s_seen != il_s);
            stable = !t_s && (il_s == m_prev_il);
            m_ds   = stable ? ((m_ds < SS + 1) ? m_ds + 1 : m_ds) : 0;
            m_err  = set || (m_err && !ec_s);
            m_prev_il = il_s;
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (O !== 1'b1) begin tests_failed++; $display("FAIL reset_O: got %b want 1", O); end
        tests_run++;
        if ({RISE, FALL, ERR} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_strobes_err: got %b want 000", {RISE, FALL, ERR});
        end
    endtask

    task automatic test_clr_mid();
        I = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2 CLR = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if ({O, RISE, FALL, ERR} !== 4'b1000) begin
            tests_failed++; $display("FAIL clr_mid_immediate: got %b want 1000", {O, RISE, FALL, ERR});
        end
        #1 CLR = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            tests_run++;
            if (O !== (k < 6 ? 1'b1 : 1'b0) || FALL !== (k == 6) || RISE !== 1'b0) begin
                tests_failed++;
                $display("FAIL clr_release_edge%0d: got O=%b FALL=%b RISE=%b want O=%b FALL=%b RISE=0",
                         k, O, FALL, RISE, k < 6, k == 6);
            end
        end
    endtask

    task automatic test_step();
        I = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        tests_run++;
        if (O !== 1'b1) begin tests_failed++; $display("FAIL step_preset: got O=%b want 1", O); end
        I = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            tests_run++;
            if (O !== (k < 6 ? 1'b1 : 1'b0) || FALL !== (k == 6) || RISE !== 1'b0) begin
                tests_failed++;
                $display("FAIL step_edge%0d: got O=%b FALL=%b RISE=%b want O=%b FALL=%b RISE=0",
                         k, O, FALL, RISE, k < 6, k == 6);
            end
        end
    endtask

    task automatic test_glitch();
        int n_rise, n_fall;
        I = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        for (int len = 3; len <= 4; len++) begin
            n_rise = 0; n_fall = 0;
            I = 1'b0;
            for (int k = 0; k < len; k++) begin
                tick(); n_rise += RISE; n_fall += FALL;
            end
            I = 1'b1;
            for (int k = 0; k < 12; k++) begin
                tick(); n_rise += RISE; n_fall += FALL;
            end
            tests_run++;
            if (O !== 1'b1 || n_rise != len - 3 || n_fall != len - 3) begin
                tests_failed++;
                $display("FAIL glitch_len%0d: got O=%b rises=%0d falls=%0d want O=1 rises=%0d falls=%0d",
                         len, O, n_rise, n_fall, len - 3, len - 3);
            end
        end
    endtask

    task automatic test_ce();
        int strobes;
        strobes = 0;
        CE = 1'b0; I = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(); strobes += RISE + FALL;
        end
        tests_run++;
        if (O !== 1'b1 || strobes != 0) begin
            tests_failed++; $display("FAIL ce_hold: got O=%b strobes=%0d want O=1 strobes=0", O, strobes);
        end
        CE = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests_run++;
            if (O !== (k < 4 ? 1'b1 : 1'b0) || FALL !== (k == 4)) begin
                tests_failed++;
                $display("FAIL ce_release_edge%0d: got O=%b FALL=%b want O=%b FALL=%b", k, O, FALL, k < 4, k == 4);
            end
        end
    endtask

    task automatic test_contention();
        I = 1'b1; I_LOCAL = 1'b0; T_LOCAL = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        I = 1'b0; T_LOCAL = 1'b0; I_LOCAL = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests_run++;
            if (ERR !== (k == 5)) begin
                tests_failed++; $display("FAIL contention_edge%0d: got ERR=%b want %b", k, ERR, k == 5);
            end
        end
        ERR_CLR = 1'b1;
        tick(); tick();
        tests_run++;
        if (ERR !== 1'b1) begin tests_failed++; $display("FAIL err_clr_vs_set: got ERR=%b want 1", ERR); end
        ERR_CLR = 1'b0; T_LOCAL = 1'b1;
        tick(); tick();
        tests_run++;
        if (ERR !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got ERR=%b want 1", ERR); end
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        tests_run++;
        if (ERR !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got ERR=%b want 0", ERR); end
    endtask

    task automatic test_random();
        int run_left;
        run_left = 1;
        for (int n = 0; n < 1500; n++) begin
            run_left--;
            if (run_left == 0) begin
                I = ~I;
                run_left = $urandom_range(1, 7);
            end
            CE      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) T_LOCAL = ~T_LOCAL;
            if ($urandom_range(0, 9) == 0)  I_LOCAL = ~I_LOCAL;
            ERR_CLR = ($urandom_range(0, 19) == 0);
            tick();
            tests_run++;
            if ({O, RISE, FALL, ERR} !== {m_o, m_rise, m_fall, m_err} || (RISE && FALL)) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: got O/R/F/E=%b%b%b%b want %b%b%b%b",
                         n, O, RISE, FALL, ERR, m_o, m_rise, m_fall, m_err);
            end
        end
        ERR_CLR = 1'b0;
    endtask

    initial begin
        CLR = 1'b1; I = 1'b1; CE = 1'b1; T_LOCAL = 1'b1; I_LOCAL = 1'b0; ERR_CLR = 1'b0;
        model_reset();
        #12;
        test_reset();
        @(negedge C);
        CLR = 1'b0;
        test_clr_mid();
        test_step();
        test_glitch();
        test_ce();
        test_contention();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gtlp_bus_receiver.md
Name: gtlp_bus_receiver

Overview:
Receive-side companion for GTL+ tri-state output buffers on a shared, wired bus. Per bit, the block does four things:
- synchronizes the pad level into the fabric clock domain;
- filters glitches with a consecutive-sample counter;
- emits single-cycle edge strobes;
- checks for bus contention against the value the local driver is asserting.

It sits between the pad input and fabric logic. It runs alongside the local tri-state output buffer that shares the same pad.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
FILTER_CYCLES, 4, consecutive synchronized samples that must differ from O before O changes; legal range 1..15.
INIT, 1'b1, reset value of the synchronizer chain and O (GTL+ termination idles high).

Ports:
C  input  1  clock, rising edge.
CLR  input  1  asynchronous active-high reset.
I  input  1  pad level (asynchronous to C).
CE  input  1  filter enable; 0 freezes the filter state and O.
T_LOCAL  input  1  local driver tristate control; 0 = local buffer driving the pad.
I_LOCAL  input  1  value the local buffer drives when T_LOCAL=0.
ERR_CLR  input  1  synchronous clear of ERR.
O  output  1  filtered, synchronized bus level.
RISE  output  1  one-cycle strobe when O goes 0->1.
FALL  output  1  one-cycle strobe when O goes 1->0.
ERR  output  1  sticky contention flag.

Behaviour:
- Clock/reset: one clock C. CLR is asynchronous and active-high.
- Reset values (while CLR=1, independent of C):
  - sync chain = INIT; O = INIT;
  - filter counter = 0; drive-stable counter = 0;
  - RISE = 0; FALL = 0; ERR = 0.
- Synchronizer:
  - SYNC_STAGES flops shift on every C edge regardless of CE.
  - S = last stage.
- Filter (4-bit counter CNT):
  - If CE=0: CNT and O hold; RISE=FALL=0.
  - If CE=1 and S==O: CNT <= 0.
  - If CE=1, S!=O and CNT < FILTER_CYCLES-1: CNT <= CNT+1.
  - If CE=1, S!=O and CNT == FILTER_CYCLES-1: O <= S and CNT <= 0.
  - FILTER_CYCLES=1 means O follows S with one cycle of delay.
- Latency: a clean pad step, held, reaches O on the (SYNC_STAGES + FILTER_CYCLES)th rising edge after the step is captured. Defaults: 6 edges.
- Glitch rejection: any pulse on S shorter than FILTER_CYCLES cycles leaves O unchanged. CNT restarts from 0 on each return of S to O.
- Edge strobes:
  - RISE and FALL are registered and asserted in the same cycle O takes its new value.
  - Each is high for exactly one cycle; they are never both high.
  - They are 0 in every cycle in which O does not change.
- Contention checker:
  - Drive-stable counter DS (saturating at SYNC_STAGES+1) increments while T_LOCAL=0 and I_LOCAL is unchanged from the previous cycle.
  - DS resets to 0 when T_LOCAL=1 or I_LOCAL toggles.
  - When DS == SYNC_STAGES+1 and S != I_LOCAL, ERR <= 1 on the next edge.
  - ERR is sticky. ERR_CLR=1 clears it on the next edge, but a simultaneous set condition wins (ERR stays 1).
  - The checker ignores CE.
- Reset mid-operation: CLR assertion forces all state to reset values immediately, aborting any in-progress filter count. After CLR deasserts, the first real transition needs the full SYNC_STAGES+FILTER_CYCLES latency.
- Parameters outside their legal range are a compile-time misuse; no runtime check.

Optional Feature:
Macro GLBL_GTS_EN.
- Defined: the block reads glbl.GTS (tri0 net; undriven = 0).
  - While GTS=1, the local buffer is treated as tristated: DS is held at 0 and ERR cannot set.
  - ERR_CLR still operates.
  - O, RISE and FALL are unaffected.
- Not defined: glbl is not referenced and the checker uses T_LOCAL alone.

Test Plan:
- CLR pulse mid-cycle with I=0 held -> O=1, RISE=FALL=ERR=0 immediately; after release, O falls exactly 6 edges later, with FALL high for that single cycle.
- Defaults, CE=1, I steps 1->0 and holds -> O=0 on the 6th edge; FALL=1 for one cycle; RISE stays 0.
- I low pulse lasting 3 cycles (FILTER_CYCLES=4) -> O stays 1, no strobes. Repeat with a 4-cycle pulse -> O goes 0, then 1 again; FALL and RISE each pulse once.
- CE=0 held while I steps 1->0 for 10 cycles -> O holds 1, no strobes. CE->1 -> O=0 four edges later.
- T_LOCAL=0, I_LOCAL=1, pad held 0 by another driver -> ERR=1 on the 5th edge after drive start. Assert ERR_CLR with the condition still present -> ERR stays 1. Release the drive, then pulse ERR_CLR -> ERR=0.
- With GLBL_GTS_EN, GTS=1 during the contention stimulus above -> ERR stays 0. GTS->0 -> ERR=1 four edges later.
